// File: rtl/mantissa_serial_adder.sv
//==============================================================================
// Module : mantissa_serial_adder
// Serial 24-bit mantissa adder, SLICE_W bits per clock, behind a valid/ack port.
// Optional macro: ADDER_OPERAND_CHECK_EN (flags operand changes during CALC).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module mantissa_serial_adder #(
    parameter int SLICE_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Adder_valid,
    input  logic [23:0] Adder_datain1,
    input  logic [23:0] Adder_datain2,
    output logic [23:0] Adder_dataout,
    output logic        Adder_carryout,
    output logic [1:0]  Adder_Exc,
    output logic        Adder_ack,
    output logic        Busy
);

    localparam int N     = 24 / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_CALC     = 2'd1;
    localparam logic [1:0] c_ACK      = 2'd2;
    localparam logic [1:0] c_WAIT_LOW = 2'd3;

    logic [1:0]       r_state;
    logic [23:0]      r_opa;
    logic [23:0]      r_opb;
    logic [23:0]      r_psum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_dout;
    logic             r_cout;

    logic [4:0]         w_lsb;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W:0]   w_sum_sl;
    logic [23:0]        w_psum_next;
    logic               w_last;

    assign w_lsb    = 5'(r_idx) * 5'(SLICE_W);
    assign w_a_sl   = r_opa[w_lsb +: SLICE_W];
    assign w_b_sl   = r_opb[w_lsb +: SLICE_W];
    assign w_sum_sl = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_W{1'b0}}, r_carry};
    assign w_last   = (r_idx == c_LAST);

    always_comb begin
        w_psum_next = r_psum;
        w_psum_next[w_lsb +: SLICE_W] = w_sum_sl[SLICE_W-1:0];
    end

`ifdef ADDER_OPERAND_CHECK_EN
    logic       r_flag;
    logic [1:0] r_exc;
    logic       w_mismatch;

    // Live inputs are compared against the latched copies; the sum never uses them.
    assign w_mismatch = (Adder_datain1 != r_opa) || (Adder_datain2 != r_opb);
    assign Adder_Exc  = r_exc;
`else
    assign Adder_Exc  = 2'b00;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_dout  <= '0;
            r_cout  <= 1'b0;
`ifdef ADDER_OPERAND_CHECK_EN
            r_flag  <= 1'b0;
            r_exc   <= 2'b00;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Adder_valid) begin
                        r_opa   <= Adder_datain1;
                        r_opb   <= Adder_datain2;
                        r_psum  <= '0;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
`ifdef ADDER_OPERAND_CHECK_EN
                        r_flag  <= 1'b0;
`endif
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    // A dropped request wins over completion, even on the last slice.
                    if (!Adder_valid) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_psum  <= w_psum_next;
                        r_carry <= w_sum_sl[SLICE_W];
                        r_idx   <= r_idx + IDX_W'(1);
`ifdef ADDER_OPERAND_CHECK_EN
                        r_flag  <= r_flag | w_mismatch;
`endif
                        if (w_last) begin
                            r_dout  <= w_psum_next;
                            r_cout  <= w_sum_sl[SLICE_W];
`ifdef ADDER_OPERAND_CHECK_EN
                            r_exc   <= {1'b0, r_flag | w_mismatch};
`endif
                            r_state <= c_ACK;
                        end
                    end
                end
                c_ACK: begin
                    r_state <= c_WAIT_LOW;
                end
                c_WAIT_LOW: begin
                    if (!Adder_valid) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Adder_dataout  = r_dout;
    assign Adder_carryout = r_cout;
    assign Adder_ack      = (r_state == c_ACK);
    assign Busy           = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mantissa_serial_adder.sv
//==============================================================================
// Module : tb_mantissa_serial_adder
// Scoreboarded bench for mantissa_serial_adder (SLICE_W=4 plus 1/3/24 variants).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_mantissa_serial_adder;

    localparam int SW_MAIN = 4;
    localparam int N_MAIN  = 24 / SW_MAIN;
    localparam int SW [3]  = '{1, 3, 24};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [23:0] da = '0;
    logic [23:0] db = '0;
    logic [23:0] dout;
    logic        cout;
    logic [1:0]  exc;
    logic        ack;
    logic        busy;

    logic        x_valid [3];
    logic [23:0] x_a = '0;
    logic [23:0] x_b = '0;
    logic [23:0] x_dout [3];
    logic        x_cout [3];
    logic [1:0]  x_exc  [3];
    logic        x_ack  [3];
    logic        x_busy [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [24:0] sum;
        logic [1:0]  exc;
    } exp_t;

    exp_t        sb[$];
    logic [24:0] last_sum = '0;

    always #5 clk = ~clk;

    mantissa_serial_adder #(.SLICE_W(SW_MAIN)) u_dut (
        .CLK            (clk),
        .RST            (rst),
        .Adder_valid    (valid),
        .Adder_datain1  (da),
        .Adder_datain2  (db),
        .Adder_dataout  (dout),
        .Adder_carryout (cout),
        .Adder_Exc      (exc),
        .Adder_ack      (ack),
        .Busy           (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_var
        mantissa_serial_adder #(.SLICE_W(SW[g])) u_var (
            .CLK            (clk),
            .RST            (rst),
            .Adder_valid    (x_valid[g]),
            .Adder_datain1  (x_a),
            .Adder_datain2  (x_b),
            .Adder_dataout  (x_dout[g]),
            .Adder_carryout (x_cout[g]),
            .Adder_Exc      (x_exc[g]),
            .Adder_ack      (x_ack[g]),
            .Busy           (x_busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Full handshake: hold valid until ack, drop it one cycle after ack.
    task automatic run_req(input logic [23:0] a, input logic [23:0] b, input bit corrupt);
        exp_t e;
        int   lat;
        @(negedge clk);
        da    = a;
        db    = b;
        valid = 1'b1;
        e.sum = {1'b0, a} + {1'b0, b};
`ifdef ADDER_OPERAND_CHECK_EN
        e.exc = corrupt ? 2'b01 : 2'b00;
`else
        e.exc = 2'b00;
`endif
        sb.push_back(e);
        @(posedge clk);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (corrupt && lat == 2) db = ~b;
            if (ack) break;
        end
        check_eq("ack_latency", 32'(lat), 32'(N_MAIN));
        e = sb.pop_front();
        check_eq("dataout", 32'(dout), 32'(e.sum[23:0]));
        check_eq("carryout", 32'(cout), 32'(e.sum[24]));
        check_eq("exc", 32'(exc), 32'(e.exc));
        last_sum = e.sum;
        @(posedge clk);
        #1;
        check_eq("ack_one_cycle", 32'(ack), 32'd0);
        check_eq("busy_wait_low", 32'(busy), 32'd1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat [3];
        logic [23:0] ra;
        logic [23:0] rb;
        for (int j = 0; j < 3; j++) x_valid[j] = 1'b0;

        #12;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);
        check_eq("rst_exc", 32'(exc), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req(24'h123456, 24'h654321, 1'b0);
        run_req(24'hFFFFFF, 24'h000001, 1'b0);
        run_req(24'hC00000, 24'hC00000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            run_req(ra, rb, 1'b0);
        end

        // Abort after two CALC cycles
        @(negedge clk);
        da = 24'h0ABCDE;
        db = 24'h111111;
        valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("abort_busy_calc", 32'(busy), 32'd1);
        valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ack", 32'(ack), 32'd0);
        check_eq("abort_dout", 32'(dout), 32'(last_sum[23:0]));
        check_eq("abort_cout", 32'(cout), 32'(last_sum[24]));
        run_req(24'h00FF00, 24'h0000FF, 1'b0);

        // Operand change in the third CALC cycle
        run_req(24'h0F0F0F, 24'h111111, 1'b1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        da = 24'h700000;
        db = 24'h900001;
        valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_ack", 32'(ack), 32'd0);
        check_eq("arst_dout", 32'(dout), 32'd0);
        check_eq("arst_cout", 32'(cout), 32'd0);
        check_eq("arst_exc", 32'(exc), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        valid = 1'b0;
        #3;
        rst = 1'b0;
        run_req(24'h700000, 24'h900001, 1'b0);

        // Carry ripple across SLICE_W = 1, 3, 24
        @(negedge clk);
        x_a = 24'hFFFFFF;
        x_b = 24'h000001;
        for (int j = 0; j < 3; j++) begin
            x_valid[j] = 1'b1;
            lat[j] = 0;
        end
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++) begin
                if (x_ack[j] && lat[j] == 0) begin
                    lat[j] = c;
                    check_eq("var_dout", 32'(x_dout[j]), 32'h000000);
                    check_eq("var_cout", 32'(x_cout[j]), 32'd1);
                    check_eq("var_exc", 32'(x_exc[j]), 32'd0);
                    x_valid[j] = 1'b0;
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            check_eq("var_latency", 32'(lat[j]), 32'(24 / SW[j]));
            check_eq("var_busy_end", 32'(x_busy[j]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mantissa_serial_adder.md
# mantissa_serial_adder

- Callee-side adder unit behind the FP adder controller's Adder_valid/Adder_ack mantissa interface.
- Accepts two 24-bit mantissas and adds them serially, SLICE_W bits per clock, LSB slice first.
- Returns the 24-bit sum, carry-out and a 2-bit exception code with a one-cycle acknowledge, then waits for the request to drop.
- Sits between the adder controller and the rest of the FPU datapath; the controller pre-negates the second operand for effective subtraction, so this block only adds.

## Interface
- SLICE_W, 4, bits added per cycle; must divide 24 (legal: 1, 2, 3, 4, 6, 8, 12, 24); N = 24/SLICE_W compute cycles.
- CLK  input  1  clock; all state on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Adder_valid  input  1  request from controller; held high until it sees Adder_ack.
- Adder_datain1  input  24  operand A.
- Adder_datain2  input  24  operand B.
- Adder_dataout  output  24  registered sum A+B mod 2^24.
- Adder_carryout  output  1  registered carry out of bit 23.
- Adder_Exc  output  2  registered exception code; 2'b00 = none.
- Adder_ack  output  1  one-cycle result strobe.
- Busy  output  1  high in CALC, ACK and WAIT_LOW.

## Operation
States and transitions:
- IDLE: if Adder_valid=1, latch both operands, clear partial sum and carry, set slice index to 0, go to CALC.
- CALC:
  - Each cycle add operand slice [k*SLICE_W +: SLICE_W] plus the carry register; write that slice of the partial sum and update the carry.
  - After slice N-1, load Adder_dataout, Adder_carryout and Adder_Exc from the partial results; go to ACK.
  - If Adder_valid=0 in any CALC cycle: abort to IDLE; no ack; outputs keep their previous values.
- ACK: Adder_ack=1 for exactly this cycle; go to WAIT_LOW.
- WAIT_LOW:
  - Stay while Adder_valid=1; go to IDLE when Adder_valid=0.
  - A high Adder_valid here never starts a new operation. Every request needs a low cycle between requests.

Arithmetic and outputs:
- Result equals the 25-bit sum {carry, sum} = A + B, independent of SLICE_W.
- Adder_dataout, Adder_carryout and Adder_Exc change only on the edge entering ACK (or on reset). They stay stable through ACK, WAIT_LOW and the next operation until its own ACK.
- Operands are latched at accept. Later input changes do not affect the result, except for the exception check under Configuration.

## Timing
- Reset values: Adder_ack=0, Adder_dataout=0, Adder_carryout=0, Adder_Exc=2'b00, Busy=0, state IDLE.
- Reset mid-operation: all of the above are forced immediately, without waiting for a clock edge.
- Accept edge E0 (IDLE, valid=1) → CALC on edges E1..EN → Adder_ack high between EN and EN+1.
- Latency from accept edge to ack is N cycles (6 for SLICE_W=4; 1 for SLICE_W=24).
- The controller registers its valid, so it drops valid one cycle after ack. WAIT_LOW absorbs this, so the block returns to IDLE at the earliest on EN+2.
- Ack and a valid-low abort are mutually exclusive. A valid drop on the final CALC cycle aborts, and no ack follows.
- Minimum back-to-back period: N+3 cycles.

## Configuration
- ADDER_OPERAND_CHECK_EN defined:
  - In every CALC cycle, compare live Adder_datain1/2 against the latched operands.
  - Any mismatch sets a sticky flag for the operation.
  - At ACK, Adder_Exc=2'b01 if the flag is set, else 2'b00.
  - The sum is still computed from the latched operands.
- ADDER_OPERAND_CHECK_EN undefined: no compare logic; Adder_Exc is constant 2'b00.
- 2'b10 and 2'b11 are reserved and never driven.

## Test plan
- SLICE_W=4, A=0x123456, B=0x654321 held with valid → ack exactly 6 cycles after accept; dataout=0x777777, carry=0, Exc=00.
- A=0xFFFFFF, B=0x000001 (carry ripples across every slice) → dataout=0x000000, carry=1. Repeat with SLICE_W=1, 3 and 24 → same result, latencies 24, 8 and 1.
- A=0xC00000, B=0xC00000 (pre-negated subtract) → dataout=0x800000, carry=1. Valid drops one cycle after ack → Busy low two cycles after ack; a new request is accepted on the following edge.
- Valid deasserted after 2 CALC cycles → no ack, outputs unchanged from the prior result, IDLE next cycle. The next request completes normally.
- RST pulsed mid-CALC, between edges → ack/dataout/carry/Exc/Busy go to 0 immediately, before any clock edge. After release, a fresh request gives the correct sum.
- With ADDER_OPERAND_CHECK_EN, Adder_datain2 changed in the third CALC cycle → Exc=01 and dataout equals the sum of the latched operands. Without the macro → Exc=00.
